// File: rtl/div_issue_ctrl_pkg.sv
// Shared definitions for the EX-stage divide issue controller.
// Holds the FSM encoding, the operand width and the divider latency.
package div_issue_ctrl_pkg;

  localparam int WIDTH       = 32;
  localparam int DIV_LATENCY = 18;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/div_sign_fix.sv
// Two's-complement conditional negate.
// Produces a magnitude from a signed operand, or re-applies a sign to a result.
module div_sign_fix
  import div_issue_ctrl_pkg::*;
(
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] res_o
);

  assign res_o = neg_i ? (~val_i + {{(WIDTH-1){1'b0}}, 1'b1}) : val_i;

endmodule

// File: rtl/div_issue_ctrl.sv
// Issues DIV/DIVU to the iterative divider, stalls EX while it runs,
// sign-corrects the result and drains in-flight operations after a flush.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              div_req,
  input  logic              div_signed,
  input  logic [WIDTH-1:0]  rs_val,
  input  logic [WIDTH-1:0]  rt_val,
  input  logic              flush,
  input  logic              ext_stall,
  output logic              stall_o,
  output logic [WIDTH-1:0]  dv_a,
  output logic [WIDTH-1:0]  dv_b,
  output logic              dv_start,
  output logic              dv_busbusy,
  input  logic              dv_over,
  input  logic [WIDTH-1:0]  dv_q,
  input  logic [WIDTH-1:0]  dv_r,
  output logic              hilo_we,
  output logic [WIDTH-1:0]  hi_o,
  output logic [WIDTH-1:0]  lo_o
);

  state_e           state_q, state_d;
  logic             start_q, start_d;
  logic             hilo_we_q, hilo_we_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             stall_s;
  logic             busbusy_s;

  logic             rs_neg_s, rt_neg_s;
  logic [WIDTH-1:0] rs_mag_s, rt_mag_s, q_fix_s, r_fix_s;

  assign rs_neg_s = div_signed & rs_val[WIDTH-1];
  assign rt_neg_s = div_signed & rt_val[WIDTH-1];

  div_sign_fix u_fix_rs (.val_i(rs_val), .neg_i(rs_neg_s), .res_o(rs_mag_s));
  div_sign_fix u_fix_rt (.val_i(rt_val), .neg_i(rt_neg_s), .res_o(rt_mag_s));
  div_sign_fix u_fix_q  (.val_i(dv_q),   .neg_i(q_neg_q),  .res_o(q_fix_s));
  div_sign_fix u_fix_r  (.val_i(dv_r),   .neg_i(r_neg_q),  .res_o(r_fix_s));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      start_q   <= 1'b0;
      hilo_we_q <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      hilo_we_q <= hilo_we_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      a_q       <= a_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    hilo_we_d = 1'b0;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    a_d       = a_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    stall_s   = 1'b0;
    busbusy_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (div_req && !flush) begin
          stall_s = 1'b1;
          a_d     = rs_mag_s;
          b_d     = rt_mag_s;
          q_neg_d = rs_neg_s ^ rt_neg_s;
          r_neg_d = rs_neg_s;
          start_d = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall_s   = 1'b1;
        busbusy_s = ext_stall;
        // Start must stay high after a flush: dropping it would freeze the divider count.
        if (flush) begin
          state_d = ST_DRAIN;
        end else if (dv_over && !ext_stall) begin
          start_d   = 1'b0;
          lo_d      = q_fix_s;
          hi_d      = r_fix_s;
          hilo_we_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        stall_s = div_req;
        if (dv_over) begin
          start_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        start_d = 1'b0;
      end
    endcase
  end

  assign stall_o    = stall_s;
  assign dv_busbusy = busbusy_s;
  assign dv_start   = start_q;
  assign dv_a       = a_q;
  assign dv_b       = b_q;
  assign hilo_we    = hilo_we_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl with a behavioural radix-4 divider
// and an arithmetic reference for quotient/remainder and cycle timing.
module tb_div_issue_ctrl;
  import div_issue_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, div_req, div_signed, flush, ext_stall;
  logic [31:0] rs_val, rt_val;
  logic        stall_o, dv_start, dv_busbusy, dv_over, hilo_we;
  logic [31:0] dv_a, dv_b, dv_q, dv_r, hi_o, lo_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_issue_ctrl dut (
    .clk(clk), .rst(rst), .div_req(div_req), .div_signed(div_signed),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .ext_stall(ext_stall),
    .stall_o(stall_o), .dv_a(dv_a), .dv_b(dv_b), .dv_start(dv_start),
    .dv_busbusy(dv_busbusy), .dv_over(dv_over), .dv_q(dv_q), .dv_r(dv_r),
    .hilo_we(hilo_we), .hi_o(hi_o), .lo_o(lo_o)
  );

  // Divider model: loads on first start cycle, final count after 17 more start-high cycles.
  logic [4:0]  m_cnt;
  logic [31:0] m_q, m_r;
  assign dv_over = (m_cnt == 5'd17) ? 1'b1 : ~dv_start;
  assign dv_q    = (m_cnt == 5'd17) ? m_q : 32'hDEAD_BEEF;
  assign dv_r    = (m_cnt == 5'd17) ? m_r : 32'hBEEF_DEAD;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt <= 5'd0;
      m_q   <= 32'd0;
      m_r   <= 32'd0;
    end else if (dv_start) begin
      if (m_cnt == 5'd0) begin
        m_q   <= (dv_b == 32'd0) ? 32'hFFFF_FFFF : dv_a / dv_b;
        m_r   <= (dv_b == 32'd0) ? dv_a : dv_a % dv_b;
        m_cnt <= 5'd1;
      end else if (m_cnt == 5'd17) begin
        if (!dv_busbusy) m_cnt <= 5'd0;
      end else begin
        m_cnt <= m_cnt + 5'd1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // MIPS DIV/DIVU results; zero divisor yields all-ones magnitude quotient, dividend remainder.
  task automatic ref_div(input logic [31:0] rs, input logic [31:0] rt, input logic sgn,
                         output logic [31:0] lo, output logic [31:0] hi);
    longint a, b, q, r;
    if (rt == 32'd0) begin
      lo = (sgn && rs[31]) ? 32'd1 : 32'hFFFF_FFFF;
      hi = rs;
    end else begin
      a  = sgn ? longint'($signed(rs)) : longint'(rs);
      b  = sgn ? longint'($signed(rt)) : longint'(rt);
      q  = a / b;
      r  = a % b;
      lo = q[31:0];
      hi = r[31:0];
    end
  endtask

  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? 32'(-longint'($signed(v))) : v;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One divide starting in the current cycle; ext_stall asserted for cycles st_from..st_to.
  task automatic do_div(input logic [31:0] rs, input logic [31:0] rt, input logic sgn,
                        input int st_from, input int st_to);
    logic [31:0] elo, ehi;
    int hd;
    bit ext;
    ref_div(rs, rt, sgn, elo, ehi);
    hd = DIV_LATENCY;
    while (hd >= st_from && hd <= st_to) hd++;
    hd++;
    for (int c = 0; c <= hd; c++) begin
      ext        = (c >= st_from && c <= st_to);
      div_req    = (c < hd);
      div_signed = sgn;
      rs_val     = rs;
      rt_val     = rt;
      flush      = 1'b0;
      ext_stall  = ext;
      @(negedge clk);
      chk("stall_o", {31'd0, stall_o}, {31'd0, c < hd});
      chk("dv_start", {31'd0, dv_start}, {31'd0, c >= 1 && c < hd});
      chk("dv_busbusy", {31'd0, dv_busbusy}, {31'd0, c >= 1 && c < hd && ext});
      chk("hilo_we", {31'd0, hilo_we}, {31'd0, c == hd});
      if (c == 1) begin
        chk("dv_a", dv_a, mag(rs, sgn));
        chk("dv_b", dv_b, mag(rt, sgn));
      end
      if (c == hd) begin
        chk("lo_o", lo_o, elo);
        chk("hi_o", hi_o, ehi);
      end
      next_cycle();
    end
    div_req   = 1'b0;
    ext_stall = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rs, rt;
    logic        sg;
    int          sf, sl;
    rst = 1'b1; div_req = 1'b0; div_signed = 1'b0; flush = 1'b0; ext_stall = 1'b0;
    rs_val = 32'd0; rt_val = 32'd0;
    repeat (3) next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_start", {31'd0, dv_start}, 32'd0);
    chk("rst_we", {31'd0, hilo_we}, 32'd0);
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    chk("rst_a", dv_a, 32'd0);
    next_cycle();

    do_div(32'd100, 32'd7, 1'b0, -1, -1);
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, -1, -1);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, -1);
    do_div(32'd1000, 32'd33, 1'b0, 17, 21);
    do_div(32'hFFFF_FF00, 32'd0, 1'b1, -1, -1);

    // Flush in cycle 5, new request waits from cycle 7 until the drain completes.
    for (int c = 0; c <= 18; c++) begin
      div_req    = (c != 6);
      div_signed = 1'b1;
      rs_val     = (c < 6) ? 32'd12345 : 32'hFFFF_FF9C;
      rt_val     = (c < 6) ? 32'd11 : 32'd7;
      flush      = (c == 5);
      @(negedge clk);
      chk("fl_stall", {31'd0, stall_o}, {31'd0, c != 6});
      chk("fl_start", {31'd0, dv_start}, {31'd0, c >= 1});
      chk("fl_we", {31'd0, hilo_we}, 32'd0);
      next_cycle();
    end
    flush = 1'b0;
    do_div(32'hFFFF_FF9C, 32'd7, 1'b1, -1, -1);

    // Reset in cycle 9 of a divide.
    for (int c = 0; c <= 9; c++) begin
      div_req = 1'b1; div_signed = 1'b0; rs_val = 32'd500; rt_val = 32'd3;
      rst = (c == 9);
      next_cycle();
    end
    rst = 1'b0; div_req = 1'b0;
    @(negedge clk);
    chk("mrst_stall", {31'd0, stall_o}, 32'd0);
    chk("mrst_start", {31'd0, dv_start}, 32'd0);
    chk("mrst_busy", {31'd0, dv_busbusy}, 32'd0);
    chk("mrst_we", {31'd0, hilo_we}, 32'd0);
    chk("mrst_a", dv_a, 32'd0);
    chk("mrst_b", dv_b, 32'd0);
    chk("mrst_hi", hi_o, 32'd0);
    chk("mrst_lo", lo_o, 32'd0);
    next_cycle();
    do_div(32'd9, 32'd3, 1'b0, -1, -1);

    for (int k = 0; k < 24; k++) begin
      rs = $urandom;
      rt = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : 32'($urandom);
      if (rt[31] && $urandom_range(0, 1) == 1) rt = 32'hFFFF_FFFF - 32'($urandom_range(0, 9));
      sg = 1'($urandom_range(0, 1));
      sl = $urandom_range(0, 4);
      sf = $urandom_range(14, 22);
      do_div(rs, rt, sg, sf, (sl == 0) ? -1 : sf + sl - 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
